// File: rtl/ex_result_skid.sv
// Two-entry skid buffer for the registered execute-stage result, feeding the memory stage.
// Optional CC_FLAGS_EN adds zero/sign flags carried with every buffered entry.
module ex_result_skid #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef CC_FLAGS_EN
  output logic              out_zf,
  output logic              out_sf,
`endif
  output logic [1:0]        occ
);

  // Handshake: a beat moves on a side only in a cycle where valid and ready are both
  // high at the rising edge; ready never depends on valid, and in_ready depends on state only.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, take;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_q;   // state encoding doubles as occupancy
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

`ifdef CC_FLAGS_EN
  logic main_zf_q, main_zf_d, main_sf_q, main_sf_d;
  logic skid_zf_q, skid_zf_d, skid_sf_q, skid_sf_d;
  logic in_zf, in_sf;

  assign in_zf  = (in_data == '0);
  assign in_sf  = in_data[DATA_W-1];
  assign out_zf = main_zf_q;
  assign out_sf = main_sf_q;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
`ifdef CC_FLAGS_EN
    main_zf_d = main_zf_q;
    main_sf_d = main_sf_q;
    skid_zf_d = skid_zf_q;
    skid_sf_d = skid_sf_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
`ifdef CC_FLAGS_EN
          main_zf_d = in_zf;
          main_sf_d = in_sf;
`endif
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_d = in_data;
`ifdef CC_FLAGS_EN
          main_zf_d = in_zf;
          main_sf_d = in_sf;
`endif
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
`ifdef CC_FLAGS_EN
          skid_zf_d = in_zf;
          skid_sf_d = in_sf;
`endif
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          state_d = ST_ONE;
          main_d  = skid_q;
`ifdef CC_FLAGS_EN
          main_zf_d = skid_zf_q;
          main_sf_d = skid_sf_q;
`endif
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only drops occupancy; data registers are left stale.
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef CC_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_zf_q <= 1'b0;
      main_sf_q <= 1'b0;
      skid_zf_q <= 1'b0;
      skid_sf_q <= 1'b0;
    end else begin
      main_zf_q <= main_zf_d;
      main_sf_q <= main_sf_d;
      skid_zf_q <= skid_zf_d;
      skid_sf_q <= skid_sf_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Bench for ex_result_skid: directed scenarios plus random traffic against a capacity-2 queue model.
module tb_ex_result_skid;
  localparam int DATA_W = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
`ifdef CC_FLAGS_EN
  logic              out_zf;
  logic              out_sf;
`endif

  int errors = 0;
  int checks = 0;

  // Reference: buffered results in order, head first, at most two.
  logic [DATA_W-1:0] exp_q[$];

  ex_result_skid #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CC_FLAGS_EN
    .out_zf    (out_zf),
    .out_sf    (out_sf),
`endif
    .occ       (occ)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("occ", 32'(occ), 32'(exp_q.size()));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef CC_FLAGS_EN
      check("out_zf", 32'(out_zf), 32'(exp_q[0] == 0));
      check("out_sf", 32'(out_sf), 32'(exp_q[0][DATA_W-1]));
`endif
    end
  endtask

  // Driver: called just after a falling edge; applies inputs for one rising edge,
  // advances the model, then checks outputs at the next falling edge.
  task automatic drive_cycle(input logic iv, input logic [DATA_W-1:0] id,
                             input logic ordy, input logic fl, output logic accepted);
    logic acc, tk;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (exp_q.size() < 2);
    tk  = ordy && (exp_q.size() != 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (tk) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(id);
    end
    accepted = acc;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic acc;
    logic got;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming: results appear one cycle after each push, back to back.
    drive_cycle(1'b1, 4'd2, 1'b1, 1'b0, acc);
    check("stream_first", 32'(out_data), 32'd2);
    drive_cycle(1'b1, 4'd4, 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 4'd6, 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 4'd8, 1'b1, 1'b0, acc);
    check("stream_last", 32'(out_data), 32'd8);
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, acc);

    // Back-pressure: fill, stall 7 upstream, then drain in order.
    drive_cycle(1'b1, 4'd3, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 4'd5, 1'b0, 1'b0, acc);
    check("bp_full_occ", 32'(occ), 32'd2);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    drive_cycle(1'b1, 4'd7, 1'b0, 1'b0, acc);
    check("bp_7_stalled", 32'(acc), 32'd0);
    check("bp_hold_head", 32'(out_data), 32'd3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) drive_cycle(1'b1, 4'd7, 1'b1, 1'b0, got);
    check("bp_7_accepted", 32'(got), 32'd1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, acc);
    check("bp_drained", 32'(occ), 32'd0);

    // Simultaneous push and take with one entry held.
    drive_cycle(1'b1, 4'd9, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 4'd1, 1'b1, 1'b0, acc);
    check("simul_occ", 32'(occ), 32'd1);
    check("simul_data", 32'(out_data), 32'd1);
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, acc);

    // Flush with a full buffer and a concurrent push.
    drive_cycle(1'b1, 4'hA, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 4'hB, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 4'hC, 1'b0, 1'b1, acc);
    check("flush_occ", 32'(occ), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, acc);

`ifdef CC_FLAGS_EN
    drive_cycle(1'b1, 4'h0, 1'b0, 1'b0, acc);
    check("cc_zero_zf", 32'(out_zf), 32'd1);
    check("cc_zero_sf", 32'(out_sf), 32'd0);
    drive_cycle(1'b1, 4'h8, 1'b1, 1'b0, acc);
    check("cc_neg_zf", 32'(out_zf), 32'd0);
    check("cc_neg_sf", 32'(out_sf), 32'd1);
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, acc);
`endif

    // Asynchronous reset mid-stream with two entries held.
    drive_cycle(1'b1, 4'hD, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 4'hE, 1'b0, 1'b0, acc);
    check("pre_reset_occ", 32'(occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_occ", 32'(occ), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
